line_window_feeder: RTL and testbench

//   Producer side of the filter core's three-row pixel interface.

---
 rtl/line_window_feeder.sv | 170 +++++++++++++++++
 tb/tb_line_window_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_feeder.sv
// Producer side of the filter core's three-row interface: buffers two image lines
// and emits vertically aligned column triples (rows r-2, r-1, r) from a raster stream.
module line_window_feeder #(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] img_width,
  input  logic [ADDR_W-1:0] img_height,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              in_ready,
  output logic              validData,
  output logic              start,
  output logic [DATA_W-1:0] pixel_in1,
  output logic [DATA_W-1:0] pixel_in2,
  output logic [DATA_W-1:0] pixel_in3,
  output logic [ADDR_W-1:0] col_addr,
  output logic              frame_done,
  output logic              cfg_err
);

  // state  | meaning
  // IDLE   | waiting for frame_start, not accepting pixels
  // FILL   | rows 0 and 1, pixels only written into the line buffers
  // STREAM | rows 2..height-1, every accept emits one triple
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  localparam logic [ADDR_W:0] MAX_W_EXT = (ADDR_W+1)'(MAX_WIDTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] width_q, width_d;
  logic [ADDR_W-1:0] height_q, height_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              cfg_err_q, cfg_err_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] p1_q, p1_d;
  logic [DATA_W-1:0] p2_q, p2_d;
  logic [DATA_W-1:0] p3_q, p3_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;

  logic [DATA_W-1:0] lb_a [MAX_WIDTH];
  logic [DATA_W-1:0] lb_b [MAX_WIDTH];

  logic accept;
  logic dims_ok;
  logic last_col;
  logic last_row;
  logic emit;

  assign in_ready = (state_q != IDLE);
  assign accept   = in_valid & in_ready;
  assign emit     = accept & (state_q == STREAM);
  assign last_col = (col_q == width_q - 1'b1);
  assign last_row = (row_q == height_q - 1'b1);
  assign dims_ok  = (img_width >= ADDR_W'(3)) && ({1'b0, img_width} <= MAX_W_EXT) &&
                    (img_height >= ADDR_W'(3));

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    col_d     = col_q;
    row_d     = row_q;
    cfg_err_d = cfg_err_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    caddr_d   = caddr_q;
    valid_d   = emit;
    start_d   = emit && (row_q == ADDR_W'(2)) && (col_q == '0);
    done_d    = emit && last_col && last_row;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (emit) begin
      p1_d    = lb_a[col_q];
      p2_d    = lb_b[col_q];
      p3_d    = in_pixel;
      caddr_d = col_q;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (dims_ok) begin
            width_d   = img_width;
            height_d  = img_height;
            col_d     = '0;
            row_d     = '0;
            cfg_err_d = 1'b0;
            state_d   = FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept && last_col && (row_q == ADDR_W'(1))) state_d = STREAM;
      end
      STREAM: begin
        if (accept && last_col && last_row) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      caddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cfg_err_q <= cfg_err_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      done_q    <= done_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      caddr_q   <= caddr_d;
    end
  end

  // Line buffers carry no reset; a new frame always refills both rows before emitting.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[col_q] <= lb_b[col_q];
      lb_b[col_q] <= in_pixel;
    end
  end

  assign validData  = valid_q;
  assign start      = start_q;
  assign frame_done = done_q;
  assign pixel_in1  = p1_q;
  assign pixel_in2  = p2_q;
  assign pixel_in3  = p3_q;
  assign col_addr   = caddr_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_line_window_feeder.sv
// Bench for line_window_feeder: drives raster frames and compares emitted triples
// against triples computed directly from the image array.
module tb_line_window_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] img_width = '0;
  logic [7:0] img_height = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       in_ready, validData, start, frame_done, cfg_err;
  logic [7:0] pixel_in1, pixel_in2, pixel_in3, col_addr;

  int tests = 0;
  int fails = 0;
  int hold_err = 0;

  int          pix_q [$];
  logic [33:0] got_q [$];
  logic [33:0] exp_q [$];
  logic [31:0] prev_out = '0;
  logic        prev_rst = 1'b0;

  line_window_feeder dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .img_width(img_width), .img_height(img_height),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .validData(validData), .start(start),
    .pixel_in1(pixel_in1), .pixel_in2(pixel_in2), .pixel_in3(pixel_in3),
    .col_addr(col_addr), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Collect every emitted triple; outside valid cycles the data outputs must hold.
  always @(negedge clk) begin
    if (rst_n && validData)
      got_q.push_back({start, frame_done, col_addr, pixel_in1, pixel_in2, pixel_in3});
    if (rst_n && prev_rst && !validData &&
        {col_addr, pixel_in1, pixel_in2, pixel_in3} !== prev_out)
      hold_err++;
    prev_out = {col_addr, pixel_in1, pixel_in2, pixel_in3};
    prev_rst = rst_n;
  end

  // Reference: triple (r,c) = image[r-2][c], image[r-1][c], image[r][c] for r >= 2.
  function automatic void build_exp(input int w, input int h);
    exp_q.delete();
    for (int r = 2; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({(r == 2 && c == 0), (r == h-1 && c == w-1), 8'(c),
                         8'(pix_q[(r-2)*w+c]), 8'(pix_q[(r-1)*w+c]), 8'(pix_q[r*w+c])});
  endfunction

  task automatic fill_seq(input int n);
    pix_q.delete();
    for (int i = 1; i <= n; i++) pix_q.push_back(i);
  endtask

  // gap: 0 none, 1 idle cycle between pixels, 2 random idles; stray: pixel index carrying
  // a bad frame_start (-1 none); stop: pixels to send before returning (-1 full frame).
  task automatic drive_frame(input int w, input int h, input int gap, input int stray,
                             input int stop);
    int n;
    got_q.delete();
    @(posedge clk); #1;
    frame_start = 1'b1; img_width = 8'(w); img_height = 8'(h);
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = (stop >= 0) ? stop : w*h;
    for (int i = 0; i < n; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0; in_pixel = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_pixel = 8'(pix_q[i]);
      if (i == stray) begin
        frame_start = 1'b1; img_width = 8'd2; img_height = 8'd3;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
    in_valid = 1'b0;
    if (stop < 0) begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_pixel = 8'($urandom); frame_start = 1'($urandom);
      img_width = 8'd4; img_height = 8'd3;
      @(negedge clk);
      tests++;
      if ({in_ready, validData, start, frame_done, cfg_err, pixel_in1, pixel_in2,
           pixel_in3, col_addr} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got in_ready=%b valid=%b start=%b done=%b err=%b p=%0d,%0d,%0d col=%0d, want all 0",
                 in_ready, validData, start, frame_done, cfg_err, pixel_in1, pixel_in2,
                 pixel_in3, col_addr);
      end
    end
    frame_start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); in_pixel = 8'($urandom);
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b0 || validData !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: got in_ready=%b validData=%b, want 0 0", in_ready, validData);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    fill_seq(12);
    build_exp(4, 3);
    drive_frame(4, 3, 0, -1, -1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d triples, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_triple[%0d]: got %h, want %h", i,
                 (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
      end
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_back_to_idle: got in_ready=%b, want 0", in_ready);
    end
  endtask

  task automatic test_values();
    pix_q = '{147, 149, 19, 147, 150, 41, 147, 149, 52, 10, 20, 30};
    build_exp(3, 4);
    drive_frame(3, 4, 0, -1, -1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL values_count: got %0d triples, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL values_triple[%0d]: got %h, want %h", i,
                 (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    int h0;
    fill_seq(12);
    build_exp(4, 3);
    h0 = hold_err;
    drive_frame(4, 3, 1, -1, -1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL gaps_count: got %0d triples, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL gaps_triple[%0d]: got %h, want %h", i,
                 (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
      end
    end
    tests++;
    if (hold_err != h0) begin
      fails++;
      $display("FAIL gaps_hold: got %0d non-valid cycles with changed outputs, want 0", hold_err - h0);
    end
  endtask

  task automatic test_cfg();
    int bad_w [2] = '{2, 4};
    int bad_h [2] = '{5, 2};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b1; img_width = 8'(bad_w[k]); img_height = 8'(bad_h[k]);
      @(posedge clk); #1;
      frame_start = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (cfg_err !== 1'b1 || in_ready !== 1'b0 || validData !== 1'b0) begin
        fails++;
        $display("FAIL cfg_bad[%0d]: got cfg_err=%b in_ready=%b valid=%b, want 1 0 0",
                 k, cfg_err, in_ready, validData);
      end
    end
    fill_seq(12);
    build_exp(4, 3);
    drive_frame(4, 3, 0, 9, -1);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL cfg_cleared: got cfg_err=%b, want 0", cfg_err);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL cfg_count: got %0d triples, want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL cfg_triple[%0d]: got %h, want %h", i,
                 (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int stops [2] = '{6, 10};
    for (int k = 0; k < 2; k++) begin
      fill_seq(12);
      drive_frame(4, 3, 0, -1, stops[k]);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, validData, start, frame_done, pixel_in1, pixel_in2, pixel_in3,
           col_addr} !== '0) begin
        fails++;
        $display("FAIL midreset_clear[%0d]: got in_ready=%b valid=%b p=%0d,%0d,%0d col=%0d, want all 0",
                 k, in_ready, validData, pixel_in1, pixel_in2, pixel_in3, col_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      build_exp(4, 3);
      drive_frame(4, 3, 0, -1, -1);
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL midreset_count[%0d]: got %0d triples, want %0d", k, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        tests++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL midreset_triple[%0d][%0d]: got %h, want %h", k, i,
                   (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int w, h, h0;
    for (int it = 0; it < 5; it++) begin
      w = $urandom_range(3, 10);
      h = $urandom_range(3, 6);
      pix_q.delete();
      for (int i = 0; i < w*h; i++) pix_q.push_back($urandom_range(0, 255));
      build_exp(w, h);
      h0 = hold_err;
      drive_frame(w, h, 2, -1, -1);
      tests++;
      if (got_q.size() != exp_q.size() || hold_err != h0) begin
        fails++;
        $display("FAIL random_count[%0d]: got %0d triples (%0d hold errors), want %0d (0)",
                 it, got_q.size(), hold_err - h0, exp_q.size());
      end
      foreach (exp_q[i]) begin
        tests++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random_triple[%0d][%0d]: got %h, want %h", it, i,
                   (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_gaps();
    test_cfg();
    test_midframe_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
